sync_fifo_width_adapter: RTL and testbench

Synchronous FIFO with independent write and read data widths, in either direction (upsize or downsize), at any power-of-two ratio. Uses valid/ready handshakes on both sides and a partial-word commit (wr_last) for upsizing. Provides a synchronous flush and a fill-level output. Drop-in successor to the request/flag FIFO wrapper; used between the GLB/NoC buses and the PE-array scratchpad feeds.

---
 rtl/sync_fifo_width_adapter.sv | 171 +++++++++++++++++
 tb/tb_sync_fifo_width_adapter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_width_adapter.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_width_adapter
// Brief    : Single-clock FIFO with independent write/read widths (upsize,
//            downsize or equal) at any power-of-two ratio. Valid/ready on both
//            sides, partial-word commit on upsize, synchronous flush and a
//            fill-level output decoded from registered pointers.
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_width_adapter #(
    parameter int W_DATA_WIDTH        = 64,
    parameter int R_DATA_WIDTH        = 16,
    parameter int FIFO_DEPTH          = 256,
    parameter int ALMOST_FULL_THRESH  = 2,
    parameter int ALMOST_EMPTY_THRESH = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_flush,
    input  logic                          i_wr_valid,
    output logic                          o_wr_ready,
    input  logic [W_DATA_WIDTH-1:0]       i_wr_data,
    input  logic                          i_wr_last,
    output logic                          o_rd_valid,
    input  logic                          i_rd_ready,
    output logic [R_DATA_WIDTH-1:0]       o_rd_data,
    output logic                          o_full_flag,
    output logic                          o_empty_flag,
    output logic                          o_almost_full_flag,
    output logic                          o_almost_empty_flag,
    output logic [$clog2(FIFO_DEPTH):0]   o_fill_level
);

    localparam int c_max_w  = (W_DATA_WIDTH > R_DATA_WIDTH) ? W_DATA_WIDTH : R_DATA_WIDTH;
    localparam int c_min_w  = (W_DATA_WIDTH > R_DATA_WIDTH) ? R_DATA_WIDTH : W_DATA_WIDTH;
    localparam int c_ratio  = c_max_w / c_min_w;
    localparam int c_aw     = $clog2(FIFO_DEPTH);
    localparam int c_pw     = c_aw + 1;
    // Threshold levels clamped so extreme parameter values still decode sanely.
    localparam int c_af_lvl = (FIFO_DEPTH > ALMOST_FULL_THRESH) ? (FIFO_DEPTH - ALMOST_FULL_THRESH) : 0;
    localparam int c_ae_lvl = (ALMOST_EMPTY_THRESH > FIFO_DEPTH) ? FIFO_DEPTH : ALMOST_EMPTY_THRESH;

    if ((c_max_w % c_min_w) != 0 || (c_ratio & (c_ratio - 1)) != 0) begin : g_bad_ratio
        $error("sync_fifo_width_adapter: width ratio must be an integer power of two");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo_width_adapter: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [c_max_w-1:0] r_mem [FIFO_DEPTH];
    logic [c_pw-1:0]    r_wr_ptr;
    logic [c_pw-1:0]    r_rd_ptr;
    logic [c_pw-1:0]    w_fill;
    logic               w_full;
    logic               w_empty;
    logic               w_wr_ready;
    logic               w_rd_valid;
    logic               w_wr_acc;
    logic               w_rd_acc;
    logic               w_commit;
    logic [c_max_w-1:0] w_commit_data;
    logic               w_rd_adv;
    logic [c_max_w-1:0] w_rd_entry;
    logic [R_DATA_WIDTH-1:0] w_rd_word;

    // Flags come only from the registered pointers (and flush for handshakes).
    assign w_fill     = r_wr_ptr - r_rd_ptr;
    assign w_full     = (w_fill == c_pw'(FIFO_DEPTH));
    assign w_empty    = (w_fill == '0);
    assign w_wr_ready = !w_full && !i_flush;
    assign w_rd_valid = !w_empty && !i_flush;
    assign w_wr_acc   = i_wr_valid && w_wr_ready;
    assign w_rd_acc   = w_rd_valid && i_rd_ready;
    assign w_rd_entry = r_mem[r_rd_ptr[c_aw-1:0]];

    assign o_wr_ready          = w_wr_ready;
    assign o_rd_valid          = w_rd_valid;
    assign o_rd_data           = w_rd_valid ? w_rd_word : '0;
    assign o_full_flag         = w_full;
    assign o_empty_flag        = w_empty;
    assign o_almost_full_flag  = (w_fill >= c_pw'(c_af_lvl));
    assign o_almost_empty_flag = (w_fill <= c_pw'(c_ae_lvl));
    assign o_fill_level        = w_fill;

    // Pointer update: flush outranks any commit or read advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_commit) r_wr_ptr <= r_wr_ptr + c_pw'(1);
            if (w_rd_adv) r_rd_ptr <= r_rd_ptr + c_pw'(1);
        end
    end

    // Storage array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_commit) r_mem[r_wr_ptr[c_aw-1:0]] <= w_commit_data;
    end

    if (W_DATA_WIDTH < R_DATA_WIDTH) begin : g_upsize
        localparam int c_cw = $clog2(c_ratio);
        logic [c_max_w-1:0] r_stage;
        logic [c_max_w-1:0] w_stage_nxt;
        logic [c_cw-1:0]    r_pack_cnt;
        logic               w_pack_end;

        // Merge the incoming beat into its LSB-first sub-word slot.
        always_comb begin
            w_stage_nxt = r_stage;
            w_stage_nxt[int'(r_pack_cnt)*c_min_w +: c_min_w] = i_wr_data;
        end

        assign w_pack_end    = (r_pack_cnt == c_cw'(c_ratio - 1)) || i_wr_last;
        assign w_commit      = w_wr_acc && w_pack_end;
        assign w_commit_data = w_stage_nxt;

        // Staging register and pack counter; cleared on commit so partial words zero-fill.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_stage    <= '0;
                r_pack_cnt <= '0;
            end else if (i_flush) begin
                r_stage    <= '0;
                r_pack_cnt <= '0;
            end else if (w_wr_acc) begin
                if (w_pack_end) begin
                    r_stage    <= '0;
                    r_pack_cnt <= '0;
                end else begin
                    r_stage    <= w_stage_nxt;
                    r_pack_cnt <= r_pack_cnt + c_cw'(1);
                end
            end
        end
    end else begin : g_direct_wr
        logic w_unused_last;
        assign w_unused_last = i_wr_last;
        assign w_commit      = w_wr_acc;
        assign w_commit_data = i_wr_data;
    end

    if (W_DATA_WIDTH > R_DATA_WIDTH) begin : g_downsize
        localparam int c_cw = $clog2(c_ratio);
        logic [c_cw-1:0] r_unpack_cnt;
        logic            w_unpack_end;

        assign w_unpack_end = (r_unpack_cnt == c_cw'(c_ratio - 1));
        assign w_rd_adv     = w_rd_acc && w_unpack_end;
        assign w_rd_word    = w_rd_entry[int'(r_unpack_cnt)*c_min_w +: c_min_w];

        // Sub-word selector; the entry is released only after its last sub-word.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_unpack_cnt <= '0;
            end else if (i_flush) begin
                r_unpack_cnt <= '0;
            end else if (w_rd_acc) begin
                r_unpack_cnt <= w_unpack_end ? '0 : (r_unpack_cnt + c_cw'(1));
            end
        end
    end else begin : g_direct_rd
        assign w_rd_adv  = w_rd_acc;
        assign w_rd_word = w_rd_entry;
    end

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_width_adapter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_width_adapter
// Brief    : Self-checking bench; three instances (downsize 64->16, upsize
//            16->64, equal 16/16), all DEPTH=4, checked against queue models.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_width_adapter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: downsize 64 -> 16
    logic a_flush, a_wr_valid, a_wr_ready, a_wr_last, a_rd_valid, a_rd_ready;
    logic [63:0] a_wr_data;
    logic [15:0] a_rd_data;
    logic a_full, a_empty, a_af, a_ae;
    logic [2:0] a_fill;
    // Instance B: upsize 16 -> 64
    logic b_flush, b_wr_valid, b_wr_ready, b_wr_last, b_rd_valid, b_rd_ready;
    logic [15:0] b_wr_data;
    logic [63:0] b_rd_data;
    logic b_full, b_empty, b_af, b_ae;
    logic [2:0] b_fill;
    // Instance C: equal 16 / 16
    logic c_flush, c_wr_valid, c_wr_ready, c_wr_last, c_rd_valid, c_rd_ready;
    logic [15:0] c_wr_data;
    logic [15:0] c_rd_data;
    logic c_full, c_empty, c_af, c_ae;
    logic [2:0] c_fill;

    sync_fifo_width_adapter #(.W_DATA_WIDTH(64), .R_DATA_WIDTH(16), .FIFO_DEPTH(4),
        .ALMOST_FULL_THRESH(2), .ALMOST_EMPTY_THRESH(2)) u_a (
        .clk(clk), .rst_n(rst_n), .i_flush(a_flush), .i_wr_valid(a_wr_valid), .o_wr_ready(a_wr_ready),
        .i_wr_data(a_wr_data), .i_wr_last(a_wr_last), .o_rd_valid(a_rd_valid), .i_rd_ready(a_rd_ready),
        .o_rd_data(a_rd_data), .o_full_flag(a_full), .o_empty_flag(a_empty),
        .o_almost_full_flag(a_af), .o_almost_empty_flag(a_ae), .o_fill_level(a_fill));

    sync_fifo_width_adapter #(.W_DATA_WIDTH(16), .R_DATA_WIDTH(64), .FIFO_DEPTH(4),
        .ALMOST_FULL_THRESH(2), .ALMOST_EMPTY_THRESH(2)) u_b (
        .clk(clk), .rst_n(rst_n), .i_flush(b_flush), .i_wr_valid(b_wr_valid), .o_wr_ready(b_wr_ready),
        .i_wr_data(b_wr_data), .i_wr_last(b_wr_last), .o_rd_valid(b_rd_valid), .i_rd_ready(b_rd_ready),
        .o_rd_data(b_rd_data), .o_full_flag(b_full), .o_empty_flag(b_empty),
        .o_almost_full_flag(b_af), .o_almost_empty_flag(b_ae), .o_fill_level(b_fill));

    sync_fifo_width_adapter #(.W_DATA_WIDTH(16), .R_DATA_WIDTH(16), .FIFO_DEPTH(4),
        .ALMOST_FULL_THRESH(2), .ALMOST_EMPTY_THRESH(2)) u_c (
        .clk(clk), .rst_n(rst_n), .i_flush(c_flush), .i_wr_valid(c_wr_valid), .o_wr_ready(c_wr_ready),
        .i_wr_data(c_wr_data), .i_wr_last(c_wr_last), .o_rd_valid(c_rd_valid), .i_rd_ready(c_rd_ready),
        .o_rd_data(c_rd_data), .o_full_flag(c_full), .o_empty_flag(c_empty),
        .o_almost_full_flag(c_af), .o_almost_empty_flag(c_ae), .o_fill_level(c_fill));

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (a_empty !== 1'b1)    begin n_fail++; $display("FAIL rst_empty: got %b want 1", a_empty); end
        n_checks++; if (a_ae !== 1'b1)       begin n_fail++; $display("FAIL rst_aempty: got %b want 1", a_ae); end
        n_checks++; if (a_full !== 1'b0)     begin n_fail++; $display("FAIL rst_full: got %b want 0", a_full); end
        n_checks++; if (a_af !== 1'b0)       begin n_fail++; $display("FAIL rst_afull: got %b want 0", a_af); end
        n_checks++; if (a_fill !== 3'd0)     begin n_fail++; $display("FAIL rst_fill: got %0d want 0", a_fill); end
        n_checks++; if (a_wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b want 1", a_wr_ready); end
        n_checks++; if (a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b want 0", a_rd_valid); end
        n_checks++; if (a_rd_data !== 16'h0) begin n_fail++; $display("FAIL rst_rd_data: got %h want 0", a_rd_data); end
        n_checks++; if (b_empty !== 1'b1 || c_empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty_bc: got %b%b want 11", b_empty, c_empty); end
        #10;
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic test_downsize();
        logic [63:0] word;
        logic [15:0] exp;
        word = 64'h4444_3333_2222_1111;
        a_wr_valid = 1'b1; a_wr_data = word; a_rd_ready = 1'b1;
        cycle();
        a_wr_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp = word[16*k +: 16];
            n_checks++; if (a_rd_valid !== 1'b1) begin n_fail++; $display("FAIL ds_valid%0d: got %b want 1", k, a_rd_valid); end
            n_checks++; if (a_rd_data !== exp)   begin n_fail++; $display("FAIL ds_data%0d: got %h want %h", k, a_rd_data, exp); end
            n_checks++; if (a_fill !== 3'd1)     begin n_fail++; $display("FAIL ds_fill%0d: got %0d want 1", k, a_fill); end
            cycle();
        end
        a_rd_ready = 1'b0;
        n_checks++; if (a_fill !== 3'd0)     begin n_fail++; $display("FAIL ds_fill_end: got %0d want 0", a_fill); end
        n_checks++; if (a_empty !== 1'b1)    begin n_fail++; $display("FAIL ds_empty_end: got %b want 1", a_empty); end
        n_checks++; if (a_rd_data !== 16'h0) begin n_fail++; $display("FAIL ds_data_idle: got %h want 0", a_rd_data); end
    endtask

    task automatic test_upsize();
        logic [15:0] vals [4];
        logic [63:0] exp;
        vals = '{16'hA, 16'hB, 16'hC, 16'hD};
        exp = '0;
        b_rd_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            b_wr_valid = 1'b1; b_wr_data = vals[k]; b_wr_last = 1'b0;
            n_checks++; if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL us_staged_vis%0d: got %b want 0", k, b_rd_valid); end
            cycle();
            exp = exp | (64'(vals[k]) << (16*k));
        end
        b_wr_valid = 1'b0;
        n_checks++; if (b_rd_valid !== 1'b1) begin n_fail++; $display("FAIL us_valid: got %b want 1", b_rd_valid); end
        n_checks++; if (b_rd_data !== exp)   begin n_fail++; $display("FAIL us_data: got %h want %h", b_rd_data, exp); end
        n_checks++; if (b_fill !== 3'd1)     begin n_fail++; $display("FAIL us_fill: got %0d want 1", b_fill); end
        b_rd_ready = 1'b1; cycle(); b_rd_ready = 1'b0;
        n_checks++; if (b_empty !== 1'b1)    begin n_fail++; $display("FAIL us_empty: got %b want 1", b_empty); end
        // Partial commit: two beats, second with wr_last.
        b_wr_valid = 1'b1; b_wr_data = 16'h1; b_wr_last = 1'b0; cycle();
        n_checks++; if (b_fill !== 3'd0)     begin n_fail++; $display("FAIL us_part_fill0: got %0d want 0", b_fill); end
        b_wr_data = 16'h2; b_wr_last = 1'b1; cycle();
        b_wr_valid = 1'b0; b_wr_last = 1'b0;
        exp = 64'(16'h1) | (64'(16'h2) << 16);
        n_checks++; if (b_rd_data !== exp)   begin n_fail++; $display("FAIL us_part_data: got %h want %h", b_rd_data, exp); end
        n_checks++; if (b_fill !== 3'd1)     begin n_fail++; $display("FAIL us_part_fill: got %0d want 1", b_fill); end
        b_rd_ready = 1'b1; cycle(); b_rd_ready = 1'b0;
    endtask

    task automatic test_full_wrap();
        logic [15:0] q [$];
        logic [15:0] nxt;
        bit wacc, racc;
        int writes;
        nxt = 16'd1;
        c_rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            c_wr_valid = 1'b1; c_wr_data = nxt;
            cycle();
            q.push_back(nxt); nxt++;
            n_checks++; if (c_fill !== 3'(i+1)) begin n_fail++; $display("FAIL fw_fill%0d: got %0d want %0d", i, c_fill, i+1); end
            n_checks++; if (c_af !== (i+1 >= 2)) begin n_fail++; $display("FAIL fw_afull%0d: got %b want %b", i, c_af, (i+1 >= 2)); end
        end
        n_checks++; if (c_full !== 1'b1)     begin n_fail++; $display("FAIL fw_full: got %b want 1", c_full); end
        n_checks++; if (c_wr_ready !== 1'b0) begin n_fail++; $display("FAIL fw_wr_ready: got %b want 0", c_wr_ready); end
        // Read and write together while full: only the read is taken.
        c_wr_data = nxt; c_rd_ready = 1'b1;
        cycle();
        void'(q.pop_front());
        n_checks++; if (c_fill !== 3'd3)     begin n_fail++; $display("FAIL fw_full_rw_fill: got %0d want 3", c_fill); end
        n_checks++; if (c_rd_data !== q[0])  begin n_fail++; $display("FAIL fw_full_rw_data: got %h want %h", c_rd_data, q[0]); end
        writes = 0;
        for (int cyc = 0; cyc < 40 && writes < 8; cyc++) begin
            c_wr_data = nxt;
            wacc = (q.size() < 4);
            racc = (q.size() > 0);
            n_checks++; if (c_rd_valid !== racc) begin n_fail++; $display("FAIL fw_wrap_valid: got %b want %b", c_rd_valid, racc); end
            if (racc) begin
                n_checks++; if (c_rd_data !== q[0]) begin n_fail++; $display("FAIL fw_wrap_data: got %h want %h", c_rd_data, q[0]); end
            end
            cycle();
            if (racc) void'(q.pop_front());
            if (wacc) begin q.push_back(nxt); nxt++; writes++; end
        end
        c_wr_valid = 1'b0;
        for (int cyc = 0; cyc < 10 && q.size() > 0; cyc++) begin
            n_checks++; if (c_rd_data !== q[0]) begin n_fail++; $display("FAIL fw_drain_data: got %h want %h", c_rd_data, q[0]); end
            cycle();
            void'(q.pop_front());
        end
        c_rd_ready = 1'b0;
        n_checks++; if (c_empty !== 1'b1 || q.size() != 0) begin n_fail++; $display("FAIL fw_drain_empty: got %b want 1 (left %0d)", c_empty, q.size()); end
    endtask

    task automatic test_flush();
        logic [63:0] e0, e1, e2, e3;
        e0 = {$urandom, $urandom}; e1 = {$urandom, $urandom};
        e2 = {$urandom, $urandom}; e3 = {$urandom, $urandom};
        a_rd_ready = 1'b0;
        a_wr_valid = 1'b1; a_wr_data = e0; cycle();
        a_wr_data = e1; cycle();
        a_wr_valid = 1'b0;
        n_checks++; if (a_fill !== 3'd2)          begin n_fail++; $display("FAIL fl_fill2: got %0d want 2", a_fill); end
        a_rd_ready = 1'b1; cycle(); a_rd_ready = 1'b0;
        n_checks++; if (a_rd_data !== e0[31:16])  begin n_fail++; $display("FAIL fl_sub1: got %h want %h", a_rd_data, e0[31:16]); end
        a_flush = 1'b1; a_wr_valid = 1'b1; a_wr_data = e2; a_rd_ready = 1'b1;
        #1;
        n_checks++; if (a_wr_ready !== 1'b0 || a_rd_valid !== 1'b0) begin n_fail++; $display("FAIL fl_hs_gated: got rdy=%b vld=%b want 0 0", a_wr_ready, a_rd_valid); end
        n_checks++; if (a_rd_data !== 16'h0)      begin n_fail++; $display("FAIL fl_data_zero: got %h want 0", a_rd_data); end
        cycle();
        a_flush = 1'b0; a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        n_checks++; if (a_fill !== 3'd0)          begin n_fail++; $display("FAIL fl_fill0: got %0d want 0", a_fill); end
        n_checks++; if (a_empty !== 1'b1)         begin n_fail++; $display("FAIL fl_empty: got %b want 1", a_empty); end
        a_wr_valid = 1'b1; a_wr_data = e3; cycle(); a_wr_valid = 1'b0;
        n_checks++; if (a_rd_data !== e3[15:0])   begin n_fail++; $display("FAIL fl_unpack0: got %h want %h", a_rd_data, e3[15:0]); end
        n_checks++; if (a_fill !== 3'd1)          begin n_fail++; $display("FAIL fl_post_fill: got %0d want 1", a_fill); end
        a_rd_ready = 1'b1;
        repeat (4) cycle();
        a_rd_ready = 1'b0;
        n_checks++; if (a_empty !== 1'b1)         begin n_fail++; $display("FAIL fl_drain: got %b want 1", a_empty); end
    endtask

    task automatic test_reset_midpack();
        logic [63:0] exp;
        b_rd_ready = 1'b0;
        b_wr_valid = 1'b1; b_wr_data = 16'h11; cycle();
        b_wr_data = 16'h22; cycle();
        b_wr_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (b_empty !== 1'b1 || b_ae !== 1'b1) begin n_fail++; $display("FAIL mr_empty: got %b%b want 11", b_empty, b_ae); end
        n_checks++; if (b_full !== 1'b0 || b_af !== 1'b0)  begin n_fail++; $display("FAIL mr_full: got %b%b want 00", b_full, b_af); end
        n_checks++; if (b_fill !== 3'd0)     begin n_fail++; $display("FAIL mr_fill: got %0d want 0", b_fill); end
        n_checks++; if (b_wr_ready !== 1'b1 || b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mr_hs: got rdy=%b vld=%b want 1 0", b_wr_ready, b_rd_valid); end
        n_checks++; if (b_rd_data !== 64'h0) begin n_fail++; $display("FAIL mr_data: got %h want 0", b_rd_data); end
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle();
        exp = '0;
        for (int k = 0; k < 4; k++) begin
            b_wr_valid = 1'b1; b_wr_data = 16'(5 + k);
            n_checks++; if (b_rd_valid !== 1'b0) begin n_fail++; $display("FAIL mr_staged_vis%0d: got %b want 0", k, b_rd_valid); end
            cycle();
            exp = exp | (64'(5 + k) << (16*k));
        end
        b_wr_valid = 1'b0;
        n_checks++; if (b_rd_data !== exp)   begin n_fail++; $display("FAIL mr_data_after: got %h want %h", b_rd_data, exp); end
        n_checks++; if (b_fill !== 3'd1)     begin n_fail++; $display("FAIL mr_fill_after: got %0d want 1", b_fill); end
        b_rd_ready = 1'b1; cycle(); b_rd_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] q [$];
        logic [63:0] d;
        int nw, cyc, mfill;
        bit wacc, racc;
        nw = 0;
        cyc = 0;
        a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        while ((nw < 200 || q.size() > 0) && cyc < 5000) begin
            d = {$urandom, $urandom};
            a_wr_valid = (nw < 200) && ($urandom_range(3) != 0);
            a_wr_data  = d;
            a_rd_ready = ($urandom_range(2) != 0);
            mfill = (q.size() + 3) / 4;
            n_checks++; if (a_fill !== 3'(mfill)) begin n_fail++; $display("FAIL b2b_fill c%0d: got %0d want %0d", cyc, a_fill, mfill); end
            n_checks++; if (a_rd_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL b2b_valid c%0d: got %b want %b", cyc, a_rd_valid, (q.size() > 0)); end
            n_checks++; if (a_wr_ready !== (mfill < 4)) begin n_fail++; $display("FAIL b2b_ready c%0d: got %b want %b", cyc, a_wr_ready, (mfill < 4)); end
            if (q.size() > 0) begin
                n_checks++; if (a_rd_data !== q[0]) begin n_fail++; $display("FAIL b2b_data c%0d: got %h want %h", cyc, a_rd_data, q[0]); end
            end else begin
                n_checks++; if (a_rd_data !== 16'h0) begin n_fail++; $display("FAIL b2b_idle c%0d: got %h want 0", cyc, a_rd_data); end
            end
            wacc = a_wr_valid && (mfill < 4);
            racc = a_rd_ready && (q.size() > 0);
            cycle();
            cyc++;
            if (racc) void'(q.pop_front());
            if (wacc) begin
                for (int k = 0; k < 4; k++) q.push_back(d[16*k +: 16]);
                nw++;
            end
        end
        a_wr_valid = 1'b0; a_rd_ready = 1'b0;
        n_checks++; if (cyc >= 5000) begin n_fail++; $display("FAIL b2b_timeout: got %0d words written, want 200 and drained", nw); end
    endtask

    initial begin
        a_flush = 0; a_wr_valid = 0; a_wr_data = '0; a_wr_last = 0; a_rd_ready = 0;
        b_flush = 0; b_wr_valid = 0; b_wr_data = '0; b_wr_last = 0; b_rd_ready = 0;
        c_flush = 0; c_wr_valid = 0; c_wr_data = '0; c_wr_last = 0; c_rd_ready = 0;
        test_reset();
        test_downsize();
        test_upsize();
        test_full_wrap();
        test_flush();
        test_reset_midpack();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
